// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
//
// Holds the program counter, the instruction register and the retired
// instruction counter. It also splits the latched instruction into its
// fields for the multicycle controller. The controller owns all sequencing:
//   FETCH  : mem_addr presents pc
//   DECODE : instruction_en latches mem_rdata into the IR
//   WRITE  : pc_en advances the pc according to pc_src
// pc and pc_plus1 do not change between DECODE and WRITE, so the JAL link
// value stays valid.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          asynchronous, active-low; clears all state
//   instruction_en latch mem_rdata into the IR on this edge
//   pc_en          update the pc on this edge according to pc_src
//   pc_src         00 alu_result, 01 reg_b_data, 10 pc+1, 11 hold
//   loading        load in progress: mem_addr comes from reg_b_data
//   storing        store in progress: mem_addr comes from reg_b_data
//   mem_rdata      instruction/data word from memory
//   reg_b_data     register-file B read (jump target / ld-st address)
//   alu_result     ALU output (branch target)
//   mem_addr       memory address
//   pc             current pc (address of the instruction in the IR)
//   pc_plus1       pc+1 with wrap (JAL link value)
//   op_code        IR[15:12]
//   A_index        IR[11:8]
//   ext_op_code    IR[7:4]
//   B_index        IR[3:0]
//   imm_ext        IR[7:0] zero- or sign-extended, depending on op_code
//   ir_valid       the IR holds a fetched instruction
//   instr_count    number of pc_en edges since reset
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instruction_en,
  input  logic                  pc_en,
  input  logic [1:0]            pc_src,
  input  logic                  loading,
  input  logic                  storing,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic [WIDTH-1:0]      reg_b_data,
  input  logic [WIDTH-1:0]      alu_result,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic [3:0]            op_code,
  output logic [3:0]            A_index,
  output logic [3:0]            ext_op_code,
  output logic [3:0]            B_index,
  output logic [WIDTH-1:0]      imm_ext,
  output logic                  ir_valid,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_REGB = 2'b01;
  localparam logic [1:0] SRC_INC  = 2'b10;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0]      ir_reg;
  logic                  ir_valid_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic                  zero_ext;
  logic                  ext_bit;

  // The incrementer wraps naturally at 2^ADDR_WIDTH.
  assign pc_inc = pc_reg + ADDR_WIDTH'(1);

  always_comb begin
    pc_next = pc_reg;
    if (pc_en) begin
      case (pc_src)
        SRC_ALU:  pc_next = alu_result[ADDR_WIDTH-1:0];
        SRC_REGB: pc_next = reg_b_data[ADDR_WIDTH-1:0];
        SRC_INC:  pc_next = pc_inc;
        default:  pc_next = pc_reg;  // 11: hold
      endcase
    end
  end

  // When instruction_en and pc_en are both set, both updates take effect.
  // The IR captures the word fetched from the old pc, because mem_addr is
  // still driven from pc_reg before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_VECTOR;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      pc_reg <= pc_next;
      if (instruction_en) begin
        ir_reg       <= mem_rdata;
        ir_valid_reg <= 1'b1;
      end
      // A hold (pc_src=11) still counts as a retired instruction.
      if (pc_en) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign op_code     = ir_reg[15:12];
  assign A_index     = ir_reg[11:8];
  assign ext_op_code = ir_reg[7:4];
  assign B_index     = ir_reg[3:0];

  // Logical immediates (ANDI/ORI/XORI) and LUI use a zero-extended
  // immediate. Every other op code uses a sign-extended immediate.
  always_comb begin
    zero_ext = 1'b0;
    case (ir_reg[15:12])
      4'b0001, 4'b0010, 4'b0011, 4'b1111: zero_ext = 1'b1;
      default:                            zero_ext = 1'b0;
    endcase
  end

  assign ext_bit      = zero_ext ? 1'b0 : ir_reg[7];
  assign imm_ext[7:0] = ir_reg[7:0];

  generate
    for (genvar gi = 8; gi < WIDTH; gi++) begin : g_imm_ext
      assign imm_ext[gi] = ext_bit;
    end
  endgenerate

  // Loads and stores address data memory through register B. At all other
  // times memory sees the pc.
  assign mem_addr    = (loading || storing) ? reg_b_data[ADDR_WIDTH-1:0] : pc_reg;
  assign pc          = pc_reg;
  assign pc_plus1    = pc_inc;
  assign ir_valid    = ir_valid_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

  logic        clk;
  logic        reset;
  logic        instruction_en;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        loading;
  logic        storing;
  logic [15:0] mem_rdata;
  logic [15:0] reg_b_data;
  logic [15:0] alu_result;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [3:0]  op_code;
  logic [3:0]  A_index;
  logic [3:0]  ext_op_code;
  logic [3:0]  B_index;
  logic [15:0] imm_ext;
  logic        ir_valid;
  logic [15:0] instr_count;

  fetch_decode_unit #(
    .WIDTH(16), .ADDR_WIDTH(16), .RESET_VECTOR(16'h0000), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .instruction_en(instruction_en), .pc_en(pc_en),
    .pc_src(pc_src), .loading(loading), .storing(storing), .mem_rdata(mem_rdata),
    .reg_b_data(reg_b_data), .alu_result(alu_result), .mem_addr(mem_addr),
    .pc(pc), .pc_plus1(pc_plus1), .op_code(op_code), .A_index(A_index),
    .ext_op_code(ext_op_code), .B_index(B_index), .imm_ext(imm_ext),
    .ir_valid(ir_valid), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e_pc;
    logic [15:0] e_addr;
    logic [15:0] e_pcp1;
    logic [3:0]  e_op;
    logic [3:0]  e_a;
    logic [3:0]  e_ext;
    logic [3:0]  e_b;
    logic [15:0] e_imm;
    logic        e_valid;
    logic [15:0] e_cnt;
  } exp_t;

  typedef struct {
    logic        ie;
    logic        pe;
    logic [1:0]  src;
    logic        ld;
    logic        st;
    logic [15:0] rdata;
    logic [15:0] rb;
    logic [15:0] alu;
    exp_t        exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " pc"},          pc,                 e.e_pc);
    chk({tag, " mem_addr"},    mem_addr,           e.e_addr);
    chk({tag, " pc_plus1"},    pc_plus1,           e.e_pcp1);
    chk({tag, " op_code"},     {12'h0, op_code},     {12'h0, e.e_op});
    chk({tag, " A_index"},     {12'h0, A_index},     {12'h0, e.e_a});
    chk({tag, " ext_op_code"}, {12'h0, ext_op_code}, {12'h0, e.e_ext});
    chk({tag, " B_index"},     {12'h0, B_index},     {12'h0, e.e_b});
    chk({tag, " imm_ext"},     imm_ext,            e.e_imm);
    chk({tag, " ir_valid"},    {15'h0, ir_valid},  {15'h0, e.e_valid});
    chk({tag, " instr_count"}, instr_count,        e.e_cnt);
  endtask

  task automatic idle_inputs();
    instruction_en = 1'b0; pc_en = 1'b0; pc_src = 2'b00;
    loading = 1'b0; storing = 1'b0;
    mem_rdata = 16'h0; reg_b_data = 16'h0; alu_result = 16'h0;
  endtask

  exp_t zero_exp;
  exp_t e;

  initial begin
    // {ie, pe, src, ld, st, rdata, rb, alu, {pc, addr, pc+1, op, A, ext, B, imm, valid, count}}
    vecs[0]  = '{1, 0, 2'b00, 0, 0, 16'h5A83, 16'h0000, 16'h0000, '{16'h0000, 16'h0000, 16'h0001, 4'h5, 4'hA, 4'h8, 4'h3, 16'hFF83, 1, 16'd0}};
    vecs[1]  = '{1, 1, 2'b10, 0, 0, 16'h1AFF, 16'h0000, 16'h0000, '{16'h0001, 16'h0001, 16'h0002, 4'h1, 4'hA, 4'hF, 4'hF, 16'h00FF, 1, 16'd1}};
    vecs[2]  = '{1, 1, 2'b01, 0, 0, 16'hFA80, 16'h0200, 16'h0000, '{16'h0200, 16'h0200, 16'h0201, 4'hF, 4'hA, 4'h8, 4'h0, 16'h0080, 1, 16'd2}};
    vecs[3]  = '{1, 1, 2'b00, 0, 0, 16'hC07F, 16'h0000, 16'h01F0, '{16'h01F0, 16'h01F0, 16'h01F1, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd3}};
    vecs[4]  = '{0, 0, 2'b10, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, '{16'h01F0, 16'h01F0, 16'h01F1, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd3}};
    vecs[5]  = '{0, 1, 2'b11, 0, 0, 16'h0000, 16'h0000, 16'h0000, '{16'h01F0, 16'h01F0, 16'h01F1, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd4}};
    vecs[6]  = '{0, 1, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0040, '{16'h0040, 16'h0040, 16'h0041, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd5}};
    vecs[7]  = '{0, 0, 2'b00, 1, 0, 16'h0000, 16'h1234, 16'h0000, '{16'h0040, 16'h1234, 16'h0041, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd5}};
    vecs[8]  = '{0, 0, 2'b00, 0, 1, 16'h0000, 16'hABCD, 16'h0000, '{16'h0040, 16'hABCD, 16'h0041, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd5}};
    vecs[9]  = '{0, 0, 2'b00, 0, 0, 16'h0000, 16'hABCD, 16'h0000, '{16'h0040, 16'h0040, 16'h0041, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd5}};
    vecs[10] = '{0, 1, 2'b01, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, '{16'hFFFF, 16'hFFFF, 16'h0000, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd6}};
    vecs[11] = '{0, 1, 2'b10, 0, 0, 16'h0000, 16'h0000, 16'h0000, '{16'h0000, 16'h0000, 16'h0001, 4'hC, 4'h0, 4'h7, 4'hF, 16'h007F, 1, 16'd7}};
    vecs[12] = '{1, 0, 2'b00, 0, 0, 16'h2380, 16'h0000, 16'h0000, '{16'h0000, 16'h0000, 16'h0001, 4'h2, 4'h3, 4'h8, 4'h0, 16'h0080, 1, 16'd7}};
    vecs[13] = '{1, 0, 2'b00, 0, 0, 16'h3F90, 16'h0000, 16'h0000, '{16'h0000, 16'h0000, 16'h0001, 4'h3, 4'hF, 4'h9, 4'h0, 16'h0090, 1, 16'd7}};
    vecs[14] = '{1, 0, 2'b00, 0, 0, 16'h4080, 16'h0000, 16'h0000, '{16'h0000, 16'h0000, 16'h0001, 4'h4, 4'h0, 4'h8, 4'h0, 16'hFF80, 1, 16'd7}};
    vecs[15] = '{1, 1, 2'b10, 0, 0, 16'h0000, 16'h0000, 16'h0000, '{16'h0001, 16'h0001, 16'h0002, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 16'd8}};

    zero_exp = '{16'h0000, 16'h0000, 16'h0001, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 16'd0};

    // Reset state, checked while reset is still asserted.
    idle_inputs();
    reset = 1'b0;
    #12;
    chk_all("reset", zero_exp);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors: drive on the falling edge, check 1 time unit after the rising edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      instruction_en = vecs[i].ie;  pc_en = vecs[i].pe;  pc_src = vecs[i].src;
      loading = vecs[i].ld;  storing = vecs[i].st;
      mem_rdata = vecs[i].rdata;  reg_b_data = vecs[i].rb;  alu_result = vecs[i].alu;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard: got empty queue, expected an entry for vec %0d", i);
      end else begin
        e = sb_q.pop_front();
        chk_all($sformatf("vec%0d", i), e);
      end
      $display("[TB] vec %0d: pc=%h mem_addr=%h op=%h imm=%h count=%0d", i, pc, mem_addr, op_code, imm_ext, instr_count);
    end

    // Reset is asserted between DECODE and WRITE while a pc update is pending.
    @(negedge clk);
    idle_inputs();
    instruction_en = 1'b1; mem_rdata = 16'h5A83;
    @(posedge clk);
    #1;
    chk("pre-reset op_code", {12'h0, op_code}, 16'h0005);
    @(negedge clk);
    instruction_en = 1'b0; pc_en = 1'b1; pc_src = 2'b00; alu_result = 16'h3333;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async reset", zero_exp);
    @(posedge clk);
    #1;
    chk_all("reset held over edge", zero_exp);
    $display("[TB] mid-instruction reset: pc=%h count=%0d ir_valid=%b", pc, instr_count, ir_valid);

    // The first edge after release behaves normally.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post-release pc", pc, 16'h3333);
    chk("post-release count", instr_count, 16'd1);
    chk("post-release pc_plus1", pc_plus1, 16'h3334);
    $display("[TB] post-release: pc=%h count=%0d", pc, instr_count);

    // Leftover scoreboard entries mean some expected outputs were never checked.
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: got %0d entries, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
